// File: rtl/bash_round_scheduler.sv
// Round sequencer for the whack-a-box game: steps the LFSR box picker, flashes the chosen
// box through the VGA drawer, times the player's hit window and keeps score/misses/rounds.
module bash_round_scheduler #(
    parameter int unsigned WINDOW_CYCLES = 32'd50000000,
    parameter int unsigned GAP_CYCLES    = 32'd12500000,
    parameter int unsigned ROUNDS        = 32'd16,
    parameter int unsigned MAX_MISSES    = 32'd3,
    parameter int unsigned MAX_RETRY     = 32'd3
) (
    input  logic       CLOCK_50,
    input  logic       reset_signal,
    input  logic       start,
    input  logic [2:0] lfsr_box,
    output logic       lfsr_step,
    output logic       draw_req,
    input  logic       draw_ack,
    input  logic       hit_valid,
    input  logic [2:0] hit_box,
    output logic [2:0] show_box,
    output logic       show_valid,
    output logic [7:0] score,
    output logic [2:0] misses,
    output logic [7:0] round_num,
    output logic       game_over
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_STEP   = 3'd1;
    localparam logic [2:0] S_CAPT   = 3'd2;
    localparam logic [2:0] S_DRAW   = 3'd3;
    localparam logic [2:0] S_ARMED  = 3'd4;
    localparam logic [2:0] S_RESULT = 3'd5;
    localparam logic [2:0] S_GAP    = 3'd6;
    localparam logic [2:0] S_OVER   = 3'd7;

    localparam int WIN_W = (WINDOW_CYCLES > 32'd1) ? $clog2(WINDOW_CYCLES) : 32'd1;
    localparam int GAP_W = (GAP_CYCLES > 32'd1) ? $clog2(GAP_CYCLES) : 32'd1;

    logic [2:0]       state_r, state_s;
    logic             start_q_r;
    logic [2:0]       cur_box_r, cur_box_s;
    logic [2:0]       prev_box_r, prev_box_s;
    logic [7:0]       retry_r, retry_s;
    logic [WIN_W-1:0] win_cnt_r, win_cnt_s;
    logic [GAP_W-1:0] gap_cnt_r, gap_cnt_s;
    logic             hit_r, hit_s;
    logic [7:0]       score_s;
    logic [2:0]       misses_s;
    logic [7:0]       round_s;
    logic             start_edge_s;
    logic             box_ok_s;

    // Next-state and next-datapath logic for the round sequencer.
    always_comb begin
        state_s      = state_r;
        cur_box_s    = cur_box_r;
        prev_box_s   = prev_box_r;
        retry_s      = retry_r;
        win_cnt_s    = win_cnt_r;
        gap_cnt_s    = gap_cnt_r;
        hit_s        = hit_r;
        score_s      = score;
        misses_s     = misses;
        round_s      = round_num;
        start_edge_s = start & ~start_q_r;
        box_ok_s     = (lfsr_box >= 3'd2) && (lfsr_box <= 3'd5);

        case (state_r)
            S_IDLE, S_OVER: begin
                if (start_edge_s) begin
                    score_s    = 8'd0;
                    misses_s   = 3'd0;
                    round_s    = 8'd0;
                    retry_s    = 8'd0;
                    prev_box_s = 3'd0;
                    state_s    = S_STEP;
                end else begin
                    state_s    = state_r;
                end
            end
            S_STEP: begin
                state_s = S_CAPT;
            end
            S_CAPT: begin
                // Re-roll invalid or repeated boxes until the retry budget runs out.
                if ((!box_ok_s || (lfsr_box == prev_box_r)) && (retry_r < 8'(MAX_RETRY))) begin
                    retry_s = retry_r + 8'd1;
                    state_s = S_STEP;
                end else begin
                    cur_box_s  = box_ok_s ? lfsr_box : 3'd2;
                    prev_box_s = box_ok_s ? lfsr_box : 3'd2;
                    retry_s    = 8'd0;
                    state_s    = S_DRAW;
                end
            end
            S_DRAW: begin
                if (draw_ack) begin
                    win_cnt_s = WIN_W'(WINDOW_CYCLES - 32'd1);
                    state_s   = S_ARMED;
                end else begin
                    state_s   = S_DRAW;
                end
            end
            S_ARMED: begin
                // A hit on the last window cycle still wins over the timeout.
                if (hit_valid) begin
                    hit_s   = (hit_box == cur_box_r);
                    state_s = S_RESULT;
                end else if (win_cnt_r == {WIN_W{1'b0}}) begin
                    hit_s   = 1'b0;
                    state_s = S_RESULT;
                end else begin
                    win_cnt_s = win_cnt_r - {{(WIN_W-1){1'b0}}, 1'b1};
                end
            end
            S_RESULT: begin
                if (hit_r) begin
                    if (score != 8'hFF) begin
                        score_s = score + 8'd1;
                    end else begin
                        score_s = score;
                    end
                end else begin
                    misses_s = misses + 3'd1;
                end
                round_s = round_num + 8'd1;
                if ((misses_s == 3'(MAX_MISSES)) || (round_s == 8'(ROUNDS))) begin
                    state_s = S_OVER;
                end else begin
                    gap_cnt_s = GAP_W'(GAP_CYCLES - 32'd1);
                    state_s   = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_cnt_r == {GAP_W{1'b0}}) begin
                    state_s = S_STEP;
                end else begin
                    gap_cnt_s = gap_cnt_r - {{(GAP_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State, datapath and outputs; outputs are decoded from the next state so they line up with it.
    always_ff @(posedge CLOCK_50 or posedge reset_signal) begin
        if (reset_signal) begin
            state_r    <= S_IDLE;
            start_q_r  <= 1'b0;
            cur_box_r  <= 3'd0;
            prev_box_r <= 3'd0;
            retry_r    <= 8'd0;
            win_cnt_r  <= {WIN_W{1'b0}};
            gap_cnt_r  <= {GAP_W{1'b0}};
            hit_r      <= 1'b0;
            score      <= 8'd0;
            misses     <= 3'd0;
            round_num  <= 8'd0;
            lfsr_step  <= 1'b0;
            draw_req   <= 1'b0;
            show_box   <= 3'd0;
            show_valid <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            state_r    <= state_s;
            start_q_r  <= start;
            cur_box_r  <= cur_box_s;
            prev_box_r <= prev_box_s;
            retry_r    <= retry_s;
            win_cnt_r  <= win_cnt_s;
            gap_cnt_r  <= gap_cnt_s;
            hit_r      <= hit_s;
            score      <= score_s;
            misses     <= misses_s;
            round_num  <= round_s;
            lfsr_step  <= (state_s == S_STEP);
            draw_req   <= (state_s == S_DRAW);
            show_box   <= ((state_s == S_DRAW) || (state_s == S_ARMED)) ? cur_box_s : 3'd0;
            show_valid <= (state_s == S_ARMED);
            game_over  <= (state_s == S_OVER);
        end
    end

endmodule

// File: tb/tb_bash_round_scheduler.sv
// Bench for bash_round_scheduler: a table of hand-derived rounds, reset corner cases, then
// random games checked against a round-level model of the game rules.
`timescale 1ns/1ps
module tb_bash_round_scheduler;

    localparam int W  = 8;
    localparam int G  = 4;
    localparam int R  = 3;
    localparam int M  = 2;
    localparam int MR = 3;
    localparam int A_HIT = 0, A_WRONG = 1, A_TIMEOUT = 2;

    logic       CLOCK_50 = 1'b0;
    logic       reset_signal, start, draw_ack, hit_valid;
    logic [2:0] lfsr_box, hit_box;
    logic       lfsr_step, draw_req, show_valid, game_over;
    logic [2:0] show_box, misses;
    logic [7:0] score, round_num;
    logic [25:0] outs_s;

    bash_round_scheduler #(
        .WINDOW_CYCLES(W), .GAP_CYCLES(G), .ROUNDS(R), .MAX_MISSES(M), .MAX_RETRY(MR)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset_signal(reset_signal), .start(start),
        .lfsr_box(lfsr_box), .lfsr_step(lfsr_step), .draw_req(draw_req),
        .draw_ack(draw_ack), .hit_valid(hit_valid), .hit_box(hit_box),
        .show_box(show_box), .show_valid(show_valid), .score(score),
        .misses(misses), .round_num(round_num), .game_over(game_over)
    );

    assign outs_s = {lfsr_step, draw_req, show_box, show_valid, score, misses, round_num, game_over};

    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic [2:0] c0, c1, c2, c3;
        bit         restart;
        int         action, offset;
        int         e_box, e_steps, e_score, e_miss, e_round, e_over;
    } vec_t;

    vec_t       tbl[9];
    int         vec_cnt = 0;
    int         fail_cnt = 0;
    logic [2:0] box_q[$];
    int         steps_seen, tick_n, first_step_tick;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock; the LFSR feeder hands out the next code whenever a step pulse is seen.
    task automatic tick();
        @(negedge CLOCK_50);
        tick_n++;
        if (lfsr_step === 1'b1) begin
            steps_seen++;
            if (first_step_tick < 0) first_step_tick = tick_n;
            if (box_q.size() > 0) lfsr_box = box_q.pop_front();
        end
    endtask

    function automatic logic [3:0][2:0] mk(input logic [2:0] a, b, c, d);
        mk = {d, c, b, a};
    endfunction

    function automatic logic [2:0] other_box(input logic [2:0] b);
        other_box = (b == 3'd5) ? 3'd2 : b + 3'd1;
    endfunction

    // Round-level rule: first draw that is valid and new wins; the last allowed draw is
    // always taken, with an invalid code replaced by box 2.
    function automatic void model_pick(input int prev, input logic [3:0][2:0] codes,
                                       output int box, output int steps);
        bit found;
        found = 1'b0; box = 0; steps = 0;
        for (int i = 0; i <= MR; i++) begin
            int c; bit ok;
            c  = int'(codes[i]);
            ok = (c >= 2) && (c <= 5);
            if (!found && ((ok && c != prev) || i == MR)) begin
                found = 1'b1;
                box   = ok ? c : 2;
                steps = i + 1;
            end
        end
    endfunction

    task automatic load_codes(input logic [3:0][2:0] codes);
        box_q.delete();
        for (int i = 0; i < 4; i++) box_q.push_back(codes[i]);
        steps_seen = 0; tick_n = 0; first_step_tick = -1;
    endtask

    task automatic wait_draw();
        int n;
        n = 0;
        while (draw_req !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        check("draw_req_raised", 32'(draw_req), 32'd1);
    endtask

    task automatic apply_row(input string tag, input logic [3:0][2:0] codes, input bit restart,
                             input int action, input int offset, input int e_box, input int e_steps,
                             input int pre_s, input int pre_m, input int e_s, input int e_m,
                             input int e_r, input int e_o);
        int win_len, gap_ticks, steps;
        load_codes(codes);
        if (restart) begin
            start = 1'b1; tick(); start = 1'b0;
        end
        wait_draw();
        steps = steps_seen;
        gap_ticks = first_step_tick;
        check({tag, "_box"}, 32'(show_box), e_box);
        check({tag, "_steps"}, steps, e_steps);
        check({tag, "_pre_score"}, 32'(score), pre_s);
        check({tag, "_pre_miss"}, 32'(misses), pre_m);
        if (!restart) check({tag, "_gap"}, gap_ticks, G);
        draw_ack = 1'b1; tick(); draw_ack = 1'b0;
        win_len = 0;
        if (action == A_TIMEOUT) begin
            while (show_valid === 1'b1 && win_len < 3 * W) begin
                tick();
                win_len++;
            end
            check({tag, "_window_len"}, win_len, W);
        end else begin
            repeat (offset) tick();
            check({tag, "_window_open"}, 32'(show_valid), 32'd1);
            hit_valid = 1'b1;
            hit_box = (action == A_HIT) ? 3'(e_box) : other_box(3'(e_box));
            tick();
            hit_valid = 1'b0;
        end
        tick();
        check({tag, "_score"}, 32'(score), e_s);
        check({tag, "_misses"}, 32'(misses), e_m);
        check({tag, "_round"}, 32'(round_num), e_r);
        check({tag, "_over"}, 32'(game_over), e_o);
        check({tag, "_box_cleared"}, {show_valid, show_box}, 32'd0);
    endtask

    initial begin
        int p_s, p_m;
        logic [3:0][2:0] codes;
        int m_score, m_miss, m_round, m_prev, e_box, e_steps, act, off, pre_s, pre_m;
        bit over, first;

        tbl[0] = '{3'd3, 3'd3, 3'd3, 3'd3, 1'b1, A_HIT,     2, 3, 1, 1, 0, 1, 0};
        tbl[1] = '{3'd5, 3'd5, 3'd5, 3'd5, 1'b0, A_WRONG,   3, 5, 1, 1, 1, 2, 0};
        tbl[2] = '{3'd5, 3'd5, 3'd5, 3'd5, 1'b0, A_TIMEOUT, 0, 5, 4, 1, 2, 3, 1};
        tbl[3] = '{3'd5, 3'd5, 3'd5, 3'd5, 1'b1, A_TIMEOUT, 0, 5, 1, 0, 1, 1, 0};
        tbl[4] = '{3'd4, 3'd4, 3'd4, 3'd4, 1'b0, A_WRONG,   5, 4, 1, 0, 2, 2, 1};
        tbl[5] = '{3'd1, 3'd1, 3'd1, 3'd1, 1'b1, A_HIT,     7, 2, 4, 1, 0, 1, 0};
        tbl[6] = '{3'd2, 3'd6, 3'd0, 3'd4, 1'b0, A_HIT,     0, 4, 4, 2, 0, 2, 0};
        tbl[7] = '{3'd4, 3'd4, 3'd3, 3'd3, 1'b0, A_HIT,     7, 3, 3, 3, 0, 3, 1};
        tbl[8] = '{3'd3, 3'd3, 3'd3, 3'd3, 1'b1, A_HIT,     1, 3, 1, 1, 0, 1, 0};

        reset_signal = 1'b1; start = 1'b0; draw_ack = 1'b0; hit_valid = 1'b0;
        hit_box = 3'd0; lfsr_box = 3'd0;
        steps_seen = 0; tick_n = 0; first_step_tick = -1;
        repeat (3) @(negedge CLOCK_50);
        check("reset_state", 32'(outs_s), 32'd0);
        reset_signal = 1'b0;
        tick();

        p_s = 0; p_m = 0;
        for (int i = 0; i < 9; i++) begin
            if (tbl[i].restart) begin
                p_s = 0; p_m = 0;
            end
            apply_row($sformatf("row%0d", i), mk(tbl[i].c0, tbl[i].c1, tbl[i].c2, tbl[i].c3),
                      tbl[i].restart, tbl[i].action, tbl[i].offset, tbl[i].e_box, tbl[i].e_steps,
                      p_s, p_m, tbl[i].e_score, tbl[i].e_miss, tbl[i].e_round, tbl[i].e_over);
            p_s = tbl[i].e_score; p_m = tbl[i].e_miss;
        end

        // Reset while a draw request is pending.
        load_codes(mk(3'd4, 3'd4, 3'd4, 3'd4));
        wait_draw();
        reset_signal = 1'b1; #1;
        check("reset_in_draw", 32'(outs_s), 32'd0);
        tick();
        reset_signal = 1'b0;
        apply_row("after_draw_reset", mk(3'd3, 3'd3, 3'd3, 3'd3), 1'b1, A_HIT, 4, 3, 1, 0, 0, 1, 0, 1, 0);

        // Reset while the hit window is open.
        load_codes(mk(3'd5, 3'd5, 3'd5, 3'd5));
        wait_draw();
        draw_ack = 1'b1; tick(); draw_ack = 1'b0;
        tick();
        check("armed_before_reset", 32'(show_valid), 32'd1);
        reset_signal = 1'b1; #1;
        check("reset_in_armed", 32'(outs_s), 32'd0);
        tick();
        reset_signal = 1'b0;
        steps_seen = 0;
        repeat (6) tick();
        check("idle_after_reset_no_step", steps_seen, 0);

        for (int g = 0; g < 8; g++) begin
            m_score = 0; m_miss = 0; m_round = 0; m_prev = 0; over = 1'b0; first = 1'b1;
            while (!over) begin
                for (int i = 0; i < 4; i++) begin
                    case ($urandom_range(0, 3))
                        0:       codes[i] = 3'(m_prev);
                        1:       codes[i] = 3'($urandom_range(0, 7));
                        default: codes[i] = 3'($urandom_range(2, 5));
                    endcase
                end
                act = int'($urandom_range(0, 2));
                off = int'($urandom_range(0, W - 1));
                model_pick(m_prev, codes, e_box, e_steps);
                pre_s = m_score; pre_m = m_miss;
                if (act == A_HIT) m_score = (m_score < 255) ? m_score + 1 : 255;
                else m_miss++;
                m_round++;
                over = (m_miss == M) || (m_round == R);
                apply_row($sformatf("g%0d_r%0d", g, m_round), codes, first, act, off, e_box,
                          e_steps, pre_s, pre_m, m_score, m_miss, m_round, int'(over));
                m_prev = e_box;
                first = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vec_cnt);
        $fatal(1, "watchdog");
    end

endmodule
